pipeline_stall_control: RTL and testbench
=========================================

Name: pipeline_stall_control

Overview:
Consumer of the hazard/stall requests in the 5-stage rv32i pipeline. Merges the load-use stall request, the branch-flush request and instruction/data cache wait conditions into per-stage register load enables and squash controls. Holds any cache response that arrives early while the other port is still waiting, so no response is lost during a pipeline freeze. Keeps saturating performance counters.

Parameters:
CNT_WIDTH, 32, width of each performance counter

Ports:
clk  input  1  pipeline clock
rst_n  input  1  asynchronous active-low reset
stall_pipeline  input  1  load-use stall request from hazard detection
br_flush  input  1  taken/mispredicted branch resolved in EX; squash IF/ID and ID/EX
icache_read  input  1  fetch request from IF stage
icache_resp  input  1  single-cycle icache completion pulse
icache_rdata  input  32  icache read data, valid with icache_resp
dcache_read  input  1  load request from MEM stage
dcache_write  input  1  store request from MEM stage
dcache_resp  input  1  single-cycle dcache completion pulse
dcache_rdata  input  32  dcache read data, valid with dcache_resp
icache_read_o  output  1  gated fetch request to icache
dcache_read_o  output  1  gated load request to dcache
dcache_write_o  output  1  gated store request to dcache
instr_out  output  32  instruction to IF/ID register
mem_rdata_out  output  32  load data to MEM/WB register
load_pc  output  1  PC register enable
load_if_id  output  1  IF/ID enable
load_id_ex  output  1  ID/EX enable
load_ex_mem  output  1  EX/MEM enable
load_mem_wb  output  1  MEM/WB enable
flush_if_id  output  1  load NOP into IF/ID
bubble_id_ex  output  1  load NOP control word into ID/EX
mem_stall_cnt  output  CNT_WIDTH  cycles frozen on cache wait
load_use_cnt  output  CNT_WIDTH  load-use bubbles inserted
flush_cnt  output  CNT_WIDTH  branch flushes performed

Behaviour:
- State: i_done, d_done flags; i_hold, d_hold 32-bit registers; three counters. Reset (async, rst_n low): all flags, holds and counters 0.
- dmem_req = dcache_read | dcache_write.
- i_wait = icache_read & ~i_done & ~icache_resp; d_wait = dmem_req & ~d_done & ~dcache_resp; mem_stall = i_wait | d_wait.
- Gated requests: icache_read_o = icache_read & ~i_done; dcache_read_o = dcache_read & ~d_done; dcache_write_o = dcache_write & ~d_done.
- Data: instr_out = i_done ? i_hold : icache_rdata; mem_rdata_out = d_done ? d_hold : dcache_rdata.
- Early response: icache_resp while mem_stall -> i_done<=1, i_hold<=icache_rdata. dcache_resp while mem_stall -> d_done<=1, d_hold<=dcache_rdata.
- Advance: mem_stall=0 -> i_done<=0, d_done<=0 (holds keep value, unused).
- Priority, all combinational, same cycle:
  1. mem_stall: all five loads 0; flush_if_id=0; bubble_id_ex=0. Pipeline frozen; br_flush/stall_pipeline are ignored and stay asserted since stages hold.
  2. br_flush: all loads 1; flush_if_id=1; bubble_id_ex=1. Overrides stall_pipeline, because the dependent instruction is squashed.
  3. stall_pipeline: load_pc=0, load_if_id=0, load_id_ex=1 with bubble_id_ex=1, load_ex_mem=1, load_mem_wb=1.
  4. otherwise: all loads 1, no squash.
- While rst_n low, all loads and squash outputs are 0 and gated requests are 0.
- Counters increment by 1 per cycle of each case: mem_stall_cnt in case 1, flush_cnt in case 2, load_use_cnt in case 3. Each counter saturates at all-ones and does not wrap.
- Simultaneous icache_resp and dcache_resp with no other wait: mem_stall=0; both data pass through unregistered, and the flags stay 0.
- Reset mid-stall: flags and counters clear immediately. The cache must tolerate the dropped request.

Test Plan:
- No requests, stall_pipeline=0, br_flush=0 -> all loads 1, counters unchanged for 10 cycles.
- stall_pipeline=1 for 1 cycle -> load_pc=0, load_if_id=0, bubble_id_ex=1, load_id_ex=1; load_use_cnt 0->1.
- icache_read=1, dcache_read=1; icache_resp at cycle 2 (rdata 0x00500093); dcache_resp at cycle 5 (rdata 0xDEADBEEF) -> loads 0 for cycles 0-4; icache_read_o=0 from cycle 3; at cycle 5 instr_out=0x00500093, mem_rdata_out=0xDEADBEEF, all loads 1; mem_stall_cnt=5; flags clear at cycle 6.
- br_flush=1 and stall_pipeline=1 together -> flush_if_id=1, bubble_id_ex=1, all loads 1; flush_cnt+1, load_use_cnt unchanged.
- br_flush=1 during a dcache wait of 3 cycles -> no flush for 3 cycles, flush on the resp cycle, and flush_cnt=1.
- Preload counters to all-ones via forced stall with CNT_WIDTH=4 (16 stall cycles) -> mem_stall_cnt=0xF and holds. Assert rst_n=0 mid-stall -> counters and flags 0 asynchronously.

Source files
------------

// File: rtl/pipeline_stall_control.sv
// Pipeline stall/flush arbitration for the 5-stage rv32i core: freezes on cache waits,
// holds early cache responses, and keeps saturating performance counters.
module pipeline_stall_control #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall_pipeline,
    input  logic                 br_flush,
    input  logic                 icache_read,
    input  logic                 icache_resp,
    input  logic [31:0]          icache_rdata,
    input  logic                 dcache_read,
    input  logic                 dcache_write,
    input  logic                 dcache_resp,
    input  logic [31:0]          dcache_rdata,
    output logic                 icache_read_o,
    output logic                 dcache_read_o,
    output logic                 dcache_write_o,
    output logic [31:0]          instr_out,
    output logic [31:0]          mem_rdata_out,
    output logic                 load_pc,
    output logic                 load_if_id,
    output logic                 load_id_ex,
    output logic                 load_ex_mem,
    output logic                 load_mem_wb,
    output logic                 flush_if_id,
    output logic                 bubble_id_ex,
    output logic [CNT_WIDTH-1:0] mem_stall_cnt,
    output logic [CNT_WIDTH-1:0] load_use_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                 i_done_q, i_done_d;
    logic                 d_done_q, d_done_d;
    logic [31:0]          i_hold_q, i_hold_d;
    logic [31:0]          d_hold_q, d_hold_d;
    logic [CNT_WIDTH-1:0] mem_stall_cnt_q, mem_stall_cnt_d;
    logic [CNT_WIDTH-1:0] load_use_cnt_q, load_use_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    logic dmem_req, i_wait, d_wait, mem_stall;
    logic case_stall, case_flush, case_load_use;

    assign dmem_req  = dcache_read | dcache_write;
    assign i_wait    = icache_read & ~i_done_q & ~icache_resp;
    assign d_wait    = dmem_req & ~d_done_q & ~dcache_resp;
    assign mem_stall = i_wait | d_wait;

    assign case_stall    = rst_n & mem_stall;
    assign case_flush    = rst_n & ~mem_stall & br_flush;
    assign case_load_use = rst_n & ~mem_stall & ~br_flush & stall_pipeline;

    assign icache_read_o  = rst_n & icache_read & ~i_done_q;
    assign dcache_read_o  = rst_n & dcache_read & ~d_done_q;
    assign dcache_write_o = rst_n & dcache_write & ~d_done_q;

    assign instr_out     = i_done_q ? i_hold_q : icache_rdata;
    assign mem_rdata_out = d_done_q ? d_hold_q : dcache_rdata;

    // A cache freeze outranks a branch flush: the flush request stays asserted and is honoured once unfrozen.
    always_comb begin
        load_pc      = 1'b0;
        load_if_id   = 1'b0;
        load_id_ex   = 1'b0;
        load_ex_mem  = 1'b0;
        load_mem_wb  = 1'b0;
        flush_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        if (rst_n && !mem_stall) begin
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            if (br_flush) begin
                load_pc      = 1'b1;
                load_if_id   = 1'b1;
                flush_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
            end else if (stall_pipeline) begin
                bubble_id_ex = 1'b1;
            end else begin
                load_pc    = 1'b1;
                load_if_id = 1'b1;
            end
        end
    end

    always_comb begin
        i_done_d = i_done_q;
        d_done_d = d_done_q;
        i_hold_d = i_hold_q;
        d_hold_d = d_hold_q;
        if (!mem_stall) begin
            i_done_d = 1'b0;
            d_done_d = 1'b0;
        end else begin
            if (icache_resp) begin
                i_done_d = 1'b1;
                i_hold_d = icache_rdata;
            end
            if (dcache_resp) begin
                d_done_d = 1'b1;
                d_hold_d = dcache_rdata;
            end
        end
    end

    always_comb begin
        mem_stall_cnt_d = mem_stall_cnt_q;
        load_use_cnt_d  = load_use_cnt_q;
        flush_cnt_d     = flush_cnt_q;
        if (case_stall && mem_stall_cnt_q != CNT_MAX)
            mem_stall_cnt_d = mem_stall_cnt_q + CNT_ONE;
        if (case_flush && flush_cnt_q != CNT_MAX)
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        if (case_load_use && load_use_cnt_q != CNT_MAX)
            load_use_cnt_d = load_use_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_done_q        <= 1'b0;
            d_done_q        <= 1'b0;
            i_hold_q        <= 32'h0;
            d_hold_q        <= 32'h0;
            mem_stall_cnt_q <= '0;
            load_use_cnt_q  <= '0;
            flush_cnt_q     <= '0;
        end else begin
            i_done_q        <= i_done_d;
            d_done_q        <= d_done_d;
            i_hold_q        <= i_hold_d;
            d_hold_q        <= d_hold_d;
            mem_stall_cnt_q <= mem_stall_cnt_d;
            load_use_cnt_q  <= load_use_cnt_d;
            flush_cnt_q     <= flush_cnt_d;
        end
    end

    assign mem_stall_cnt = mem_stall_cnt_q;
    assign load_use_cnt  = load_use_cnt_q;
    assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_control.sv
// Directed bench for pipeline_stall_control: stage enables, early-response holding,
// branch/stall priority and counter saturation with a narrow counter build.
module tb_pipeline_stall_control;

    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          stall_pipeline, br_flush;
    logic          icache_read, icache_resp;
    logic [31:0]   icache_rdata;
    logic          dcache_read, dcache_write, dcache_resp;
    logic [31:0]   dcache_rdata;
    logic          icache_read_o, dcache_read_o, dcache_write_o;
    logic [31:0]   instr_out, mem_rdata_out;
    logic          load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic          flush_if_id, bubble_id_ex;
    logic [CW-1:0] mem_stall_cnt, load_use_cnt, flush_cnt;

    int errorCount = 0;
    int checkCount = 0;

    pipeline_stall_control #(.CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_pipeline (stall_pipeline),
        .br_flush       (br_flush),
        .icache_read    (icache_read),
        .icache_resp    (icache_resp),
        .icache_rdata   (icache_rdata),
        .dcache_read    (dcache_read),
        .dcache_write   (dcache_write),
        .dcache_resp    (dcache_resp),
        .dcache_rdata   (dcache_rdata),
        .icache_read_o  (icache_read_o),
        .dcache_read_o  (dcache_read_o),
        .dcache_write_o (dcache_write_o),
        .instr_out      (instr_out),
        .mem_rdata_out  (mem_rdata_out),
        .load_pc        (load_pc),
        .load_if_id     (load_if_id),
        .load_id_ex     (load_id_ex),
        .load_ex_mem    (load_ex_mem),
        .load_mem_wb    (load_mem_wb),
        .flush_if_id    (flush_if_id),
        .bubble_id_ex   (bubble_id_ex),
        .mem_stall_cnt  (mem_stall_cnt),
        .load_use_cnt   (load_use_cnt),
        .flush_cnt      (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Loads packed as {pc, if_id, id_ex, ex_mem, mem_wb}; squash as {flush_if_id, bubble_id_ex}.
    function automatic logic [31:0] loads();
        return 32'({load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb});
    endfunction

    function automatic logic [31:0] squash();
        return 32'({flush_if_id, bubble_id_ex});
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic sp, input logic bf,
                                 input logic ir, input logic irsp, input logic [31:0] irdata,
                                 input logic dr, input logic dw, input logic drsp, input logic [31:0] drdata);
        stall_pipeline = sp;
        br_flush       = bf;
        icache_read    = ir;
        icache_resp    = irsp;
        icache_rdata   = irdata;
        dcache_read    = dr;
        dcache_write   = dw;
        dcache_resp    = drsp;
        dcache_rdata   = drdata;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1, 1, 1, 0, 32'h0, 1, 1, 0, 32'h0);
        #2;
        checkOutput("rst_loads", loads(), 32'h00);
        checkOutput("rst_squash", squash(), 32'h0);
        checkOutput("rst_gated", 32'({icache_read_o, dcache_read_o, dcache_write_o}), 32'h0);
        checkOutput("rst_cnt", 32'({mem_stall_cnt, load_use_cnt, flush_cnt}), 32'h0);

        $display("[TB] idle run");
        resetDut();
        for (int i = 0; i < 10; i++) begin
            checkOutput("idle_loads", loads(), 32'h1F);
            checkOutput("idle_squash", squash(), 32'h0);
            stepCycle();
        end
        checkOutput("idle_cnt", 32'({mem_stall_cnt, load_use_cnt, flush_cnt}), 32'h0);

        $display("[TB] load-use stall");
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        #1;
        checkOutput("lu_loads", loads(), 32'h07);
        checkOutput("lu_squash", squash(), 32'h1);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("lu_cnt", 32'(load_use_cnt), 32'h1);
        checkOutput("lu_other_cnt", 32'({mem_stall_cnt, flush_cnt}), 32'h0);

        $display("[TB] early icache response held during dcache wait");
        resetDut();
        for (int c = 0; c < 5; c++) begin
            if (c == 2) applyStimulus(0, 0, 1, 1, 32'h00500093, 1, 0, 0, 32'h0);
            else        applyStimulus(0, 0, 1, 0, 32'hBAD0BAD0, 1, 0, 0, 32'h0);
            #1;
            checkOutput("ms_loads", loads(), 32'h00);
            checkOutput("ms_icache_o", 32'(icache_read_o), (c >= 3) ? 32'h0 : 32'h1);
            if (c >= 3) checkOutput("ms_instr_hold", instr_out, 32'h00500093);
            stepCycle();
        end
        applyStimulus(0, 0, 1, 0, 32'hBAD0BAD0, 1, 0, 1, 32'hDEADBEEF);
        #1;
        checkOutput("ms_release_loads", loads(), 32'h1F);
        checkOutput("ms_instr", instr_out, 32'h00500093);
        checkOutput("ms_rdata", mem_rdata_out, 32'hDEADBEEF);
        stepCycle();
        checkOutput("ms_cnt", 32'(mem_stall_cnt), 32'h5);

        applyStimulus(0, 0, 1, 1, 32'h11111111, 1, 0, 1, 32'h22222222);
        #1;
        checkOutput("both_resp_icache_o", 32'(icache_read_o), 32'h1);
        checkOutput("both_resp_dcache_o", 32'(dcache_read_o), 32'h1);
        checkOutput("both_resp_loads", loads(), 32'h1F);
        checkOutput("both_resp_instr", instr_out, 32'h11111111);
        checkOutput("both_resp_rdata", mem_rdata_out, 32'h22222222);
        stepCycle();
        applyStimulus(0, 0, 1, 0, 32'h33333333, 1, 0, 0, 32'h44444444);
        #1;
        checkOutput("flags_stay_clear_i", 32'(icache_read_o), 32'h1);
        checkOutput("flags_stay_clear_d", 32'(dcache_read_o), 32'h1);
        checkOutput("flags_stay_clear_data", mem_rdata_out, 32'h44444444);

        $display("[TB] branch flush overrides load-use stall");
        resetDut();
        applyStimulus(1, 1, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        #1;
        checkOutput("bf_lu_loads", loads(), 32'h1F);
        checkOutput("bf_lu_squash", squash(), 32'h3);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("bf_lu_flush_cnt", 32'(flush_cnt), 32'h1);
        checkOutput("bf_lu_lu_cnt", 32'(load_use_cnt), 32'h0);

        $display("[TB] branch flush deferred by store wait");
        resetDut();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 1, 0, 0, 32'h0, 0, 1, 0, 32'h0);
            #1;
            checkOutput("bfw_loads", loads(), 32'h00);
            checkOutput("bfw_squash", squash(), 32'h0);
            checkOutput("bfw_write_o", 32'(dcache_write_o), 32'h1);
            stepCycle();
        end
        applyStimulus(0, 1, 0, 0, 32'h0, 0, 1, 1, 32'h0);
        #1;
        checkOutput("bfw_resp_loads", loads(), 32'h1F);
        checkOutput("bfw_resp_squash", squash(), 32'h3);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("bfw_flush_cnt", 32'(flush_cnt), 32'h1);
        checkOutput("bfw_stall_cnt", 32'(mem_stall_cnt), 32'h3);

        $display("[TB] counter saturation and reset mid-stall");
        resetDut();
        applyStimulus(0, 0, 1, 0, 32'h0, 1, 0, 1, 32'hCAFE0001);
        stepCycle();
        applyStimulus(0, 0, 1, 0, 32'h0, 1, 0, 0, 32'h0);
        #1;
        checkOutput("sat_d_held", mem_rdata_out, 32'hCAFE0001);
        checkOutput("sat_d_gated", 32'(dcache_read_o), 32'h0);
        for (int c = 1; c < 16; c++) stepCycle();
        checkOutput("sat_reach_max", 32'(mem_stall_cnt), 32'hF);
        stepCycle();
        stepCycle();
        checkOutput("sat_hold_max", 32'(mem_stall_cnt), 32'hF);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_cnt", 32'(mem_stall_cnt), 32'h0);
        checkOutput("async_rst_loads", loads(), 32'h00);
        checkOutput("async_rst_gated", 32'({icache_read_o, dcache_read_o}), 32'h0);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("async_rst_dflag", 32'(dcache_read_o), 32'h1);
        checkOutput("async_rst_rdata", mem_rdata_out, 32'h0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
